// File: rtl/barcode_pkg.sv
// rtl/barcode_pkg.sv - shared types and widths for the station-ID barcode link
package barcode_pkg;

    localparam int BC_ID_W     = 8;
    localparam int BC_PERIOD_W = 22;

    typedef enum logic [2:0] {
        IDLE,
        START_LO,
        START_HI,
        BIT_LO,
        BIT_HI,
        DONE
    } bc_tx_state_t;

endpackage

// File: rtl/bc_phase_timer.sv
// rtl/bc_phase_timer.sv - phase length timer; expires on the last cycle of a phase
module bc_phase_timer
    import barcode_pkg::*;
#(
    parameter int PW = BC_PERIOD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic [PW-1:0] len_i,
    output logic          expire_o
);

    logic [PW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A phase of length L holds its level for counts 0..L-1.
    assign expire_o = (cnt_q == (len_i - 1'b1));

endmodule

// File: rtl/barcode_tx.sv
// rtl/barcode_tx.sv - serialises an 8-bit station ID onto the barcode line BC
module barcode_tx
    import barcode_pkg::*;
#(
    parameter int MIN_PERIOD = 16,
    parameter int PW         = BC_PERIOD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               send,
    input  logic [BC_ID_W-1:0] station_ID,
    input  logic [PW-1:0]      period,
    output logic               BC,
    output logic               busy,
    output logic               done
);

    bc_tx_state_t       state_q, state_d;
    logic [BC_ID_W-1:0] shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]      pe_q, pe_d;
    logic               bc_q, bc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PW-1:0] pe_rnd;
    logic [PW-1:0] pe_req;
    logic [PW-1:0] q_len, h_len, t_len;
    logic [PW-1:0] phase_len;
    logic          msb;
    logic          expire;
    logic          timer_clr;

    // Round the request down to a multiple of 4 so Q, H and T are exact.
    assign pe_rnd = period & ~PW'(3);
    assign pe_req = (pe_rnd < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : pe_rnd;

    assign q_len = pe_q >> 2;
    assign h_len = pe_q >> 1;
    assign t_len = q_len + h_len;
    assign msb   = shift_q[BC_ID_W-1];

    always_comb begin
        phase_len = h_len;
        case (state_q)
            BIT_LO:  phase_len = msb ? q_len : t_len;
            BIT_HI:  phase_len = msb ? t_len : q_len;
            default: phase_len = h_len;
        endcase
    end

    // Timer runs only inside timed phases and restarts at every phase boundary.
    assign timer_clr = (state_q == IDLE) || (state_q == DONE) || expire;

    bc_phase_timer #(
        .PW(PW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .len_i    (phase_len),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pe_d      = pe_q;
        bc_d      = bc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d   = START_LO;
                    shift_d   = station_ID;
                    pe_d      = pe_req;
                    bit_cnt_d = '0;
                    bc_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START_LO: begin
                if (expire) begin
                    state_d = START_HI;
                    bc_d    = 1'b1;
                end
            end
            START_HI: begin
                if (expire) begin
                    state_d = BIT_LO;
                    bc_d    = 1'b0;
                end
            end
            BIT_LO: begin
                if (expire) begin
                    state_d = BIT_HI;
                    bc_d    = 1'b1;
                end
            end
            BIT_HI: begin
                if (expire) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = BIT_LO;
                        bc_d      = 1'b0;
                        shift_d   = {shift_q[BC_ID_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                bc_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                bc_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pe_q      <= '0;
            bc_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            pe_q      <= pe_d;
            bc_q      <= bc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign BC   = bc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
